boa_muldiv_seq: RTL and testbench
=================================

# boa_muldiv_seq

Iterative multi-cycle M-extension unit for the Boa³² EX stage. It replaces the single-cycle combinational multiply and divide paths with one shared 33-bit shift/add datapath driven by a small FSM, and asserts a stall toward the pipeline while an operation is in flight. It also caches the last operand pair so that fused sequences such as MULH+MUL or DIV+REM return in one cycle.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  CPU clock.
- `rst`  in  1  Reset: synchronous, active-high.
- `clear`  in  1  Abort the in-flight operation and invalidate the cache.
- `req`  in  1  EX holds a valid MULDIV instruction; held high until completion.
- `op`  in  3  funct3 of the instruction: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `lhs`  in  32  RS1 value after forwarding.
- `rhs`  in  32  RS2 value after forwarding.
- `advance`  in  1  EX/MEM barrier captures this cycle.
- `busy`  out  1  FSM is not IDLE.
- `stall_ex`  out  1  Combinational: `req && !done`.
- `done`  out  1  `result` is valid for the current request.
- `result`  out  32  Selected product half, quotient or remainder.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE, `req`=1, cache hit → DONE. Result is taken from the cached 64-bit product, or from the cached quotient/remainder. No iteration is performed.
- IDLE, `req`=1, special divide → FIX. RUN is skipped. Special cases:
  - Divide by zero: quotient 0xFFFFFFFF, remainder `lhs`.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- IDLE, `req`=1, otherwise → RUN.
  - Operands are latched as magnitudes, signed per op. MULH: both signed. MULHSU: lhs only. DIV/REM: both signed.
  - The result sign is latched: lhs⊕rhs sign for products and quotients, lhs sign for remainders.
  - The 5-bit counter is loaded with 31.
- RUN, multiply: one shift-add per cycle into a 64-bit accumulator, rhs magnitude LSB-first.
- RUN, divide: one restoring step per cycle. The 33-bit subtract uses the same adder.
- RUN exits to FIX when the counter reaches 0, i.e. after 32 cycles.
- FIX: conditional two's-complement negation of the product or quotient/remainder, then write of the cache → DONE.
- Cache contents: `lhs`, `rhs`, class (mul = `op[2]`=0 / div = `op[2]`=1), 64-bit product or quotient+remainder, signedness tag.
- A cache hit requires:
  - valid entry;
  - equal `lhs`, `rhs` and class;
  - the signedness tag matches the op's signedness. MUL matches any mul tag. DIV/REM share the signed tag; DIVU/REMU share the unsigned tag.
- DONE: `done`=1 and `result` is held stable. On `advance` → IDLE. `req` is ignored until IDLE.
- `clear` has priority over every transition. The next state is IDLE, the cache is invalidated, `done`=0, and the accumulators are don't-care.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, cache invalid, counter 0.
- `req` accepted in IDLE at cycle N. `done` rises at:
  - N+1 on a cache hit;
  - N+2 on a special divide;
  - N+34 on a full operation (32 RUN cycles + 1 FIX cycle).
- `stall_ex` is high in cycles N … done−1 and low in the cycle `done` is high.
- `advance` arriving with `done`=0 is ignored. The pipeline never advances a stalled EX.
- `req` dropping mid-RUN without `clear` is illegal. The FSM completes; the result is discarded when `advance` arrives in DONE.
- `rst` or `clear` in the same cycle as `req`: no accept, and the FSM stays in IDLE.
- Back-to-back: DONE+`advance` at cycle M gives IDLE at M+1. A new `req` is accepted at M+1.

## Structure
- Add to `boa_defines.svh`:
  - state enum `boa_muldiv_state_t`;
  - funct3 constants `RV_MUL_MUL` … `RV_MUL_REMU`.
- One sub-module, `boa_muldiv_cache`, holds the operand/result registers and hit compare. It is cleared by `rst` or `clear`.
- The shared 33-bit adder and the counter live in the top module. No second adder is allowed.

## Test plan
- MUL 7×6: `req` at N, cache empty → `done` at N+34, `result` 42. `stall_ex` high for exactly 34 cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000. The immediately following MUL on the same operands → `done` at N+1, `result` 0x00000001.
- DIV −7/2 → 0xFFFFFFFD (−3). The following REM on the same operands hits the cache → 0xFFFFFFFF (−1) at N+1. DIVU on the same operands misses the cache.
- DIV 5/0 → 0xFFFFFFFF at N+2. REM 0x80000000 / 0xFFFFFFFF → 0 at N+2.
- `clear` asserted at RUN cycle 10 → IDLE the next cycle with `done` 0. A repeat of the same request misses the cache and takes 34 cycles.
- DONE with `advance` held low for 5 cycles → `result` stable and `done` high throughout. `advance` pulse → IDLE; a new `req` one cycle later is accepted.

Source files
------------

// File: rtl/boa_muldiv_seq_pkg.sv
// rtl/boa_muldiv_seq_pkg.sv - state enum, funct3 codes and helpers for the iterative M-extension unit
package boa_muldiv_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } boa_muldiv_state_t;

    localparam logic [2:0] RV_MUL_MUL    = 3'b000;
    localparam logic [2:0] RV_MUL_MULH   = 3'b001;
    localparam logic [2:0] RV_MUL_MULHSU = 3'b010;
    localparam logic [2:0] RV_MUL_MULHU  = 3'b011;
    localparam logic [2:0] RV_MUL_DIV    = 3'b100;
    localparam logic [2:0] RV_MUL_DIVU   = 3'b101;
    localparam logic [2:0] RV_MUL_REM    = 3'b110;
    localparam logic [2:0] RV_MUL_REMU   = 3'b111;

    // Result data is the 64-bit product, or {remainder, quotient} for divides.
    function automatic logic [31:0] sel_result(input logic [2:0] op, input logic [63:0] data);
        logic sel_hi;
        sel_hi = op[2] ? op[1] : (op[1:0] != 2'b00);
        return sel_hi ? data[63:32] : data[31:0];
    endfunction

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    // Mul entries keep the full funct3 low bits; divides only keep signedness.
    function automatic logic [1:0] cache_tag(input logic [2:0] op);
        return op[2] ? {1'b0, op[0]} : op[1:0];
    endfunction

endpackage

// File: rtl/boa_muldiv_cache.sv
// rtl/boa_muldiv_cache.sv - last-operand cache so fused MULH+MUL / DIV+REM pairs finish in one cycle
module boa_muldiv_cache
    import boa_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_lhs,
    input  logic [31:0] i_wr_rhs,
    input  logic [2:0]  i_wr_op,
    input  logic [63:0] i_wr_data,
    input  logic [31:0] i_lhs,
    input  logic [31:0] i_rhs,
    input  logic [2:0]  i_op,
    output logic        o_hit,
    output logic [63:0] o_data
);

    logic        r_valid;
    logic [31:0] r_lhs;
    logic [31:0] r_rhs;
    logic        r_cls;
    logic [1:0]  r_tag;
    logic [63:0] r_data;
    logic        w_tag_ok;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_valid <= 1'b0;
            r_lhs   <= 32'd0;
            r_rhs   <= 32'd0;
            r_cls   <= 1'b0;
            r_tag   <= 2'd0;
            r_data  <= 64'd0;
        end else if (i_wr_en) begin
            r_valid <= 1'b1;
            r_lhs   <= i_wr_lhs;
            r_rhs   <= i_wr_rhs;
            r_cls   <= i_wr_op[2];
            r_tag   <= cache_tag(i_wr_op);
            r_data  <= i_wr_data;
        end
    end

    // MUL only needs the low product half, which every multiply variant shares.
    assign w_tag_ok = r_cls ? (r_tag[0] == i_op[0])
                            : ((i_op[1:0] == 2'b00) || (r_tag == i_op[1:0]));
    assign o_hit  = r_valid && (r_lhs == i_lhs) && (r_rhs == i_rhs)
                    && (r_cls == i_op[2]) && w_tag_ok;
    assign o_data = r_data;

endmodule

// File: rtl/boa_muldiv_seq.sv
// rtl/boa_muldiv_seq.sv - iterative multiply/divide unit for the Boa32 EX stage, one shared 33-bit adder
module boa_muldiv_seq
    import boa_muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] lhs,
    input  logic [31:0] rhs,
    input  logic        advance,
    output logic        busy,
    output logic        stall_ex,
    output logic        done,
    output logic [31:0] result
);

    boa_muldiv_state_t r_state;
    boa_muldiv_state_t w_state_next;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_b;
    logic [31:0] r_lhs;
    logic [31:0] r_rhs;
    logic [2:0]  r_op;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;

    logic        w_hit;
    logic [63:0] w_hit_data;
    logic        w_accept;
    logic        w_div_zero;
    logic        w_div_ovf;
    logic        w_special;
    logic        w_lhs_neg;
    logic        w_rhs_neg;
    logic [31:0] w_lhs_mag;
    logic [31:0] w_rhs_mag;
    logic [32:0] w_add_a;
    logic [32:0] w_add_b;
    logic        w_add_cin;
    logic [33:0] w_add;
    logic [63:0] w_fix_data;

    boa_muldiv_cache u_cache (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (clear),
        .i_wr_en   (r_state == ST_FIX),
        .i_wr_lhs  (r_lhs),
        .i_wr_rhs  (r_rhs),
        .i_wr_op   (r_op),
        .i_wr_data (w_fix_data),
        .i_lhs     (lhs),
        .i_rhs     (rhs),
        .i_op      (op),
        .o_hit     (w_hit),
        .o_data    (w_hit_data)
    );

    assign w_accept   = (r_state == ST_IDLE) && req && !clear;
    assign w_div_zero = (rhs == 32'd0);
    assign w_div_ovf  = !op[0] && (lhs == 32'h8000_0000) && (rhs == 32'hFFFF_FFFF);
    assign w_special  = op[2] && (w_div_zero || w_div_ovf);

    assign w_lhs_neg = lhs[31] && (op[2] ? !op[0] : ((op[1:0] == 2'b01) || (op[1:0] == 2'b10)));
    assign w_rhs_neg = rhs[31] && (op[2] ? !op[0] : (op[1:0] == 2'b01));
    assign w_lhs_mag = neg_if(w_lhs_neg, lhs);
    assign w_rhs_mag = neg_if(w_rhs_neg, rhs);

    // Multiply adds the multiplicand when the multiplier LSB is set; divide
    // computes {rem, next dividend bit} - divisor, carry-out meaning no borrow.
    assign w_add_a   = r_op[2] ? {r_hi, r_lo[31]} : {1'b0, r_hi};
    assign w_add_b   = r_op[2] ? ~{1'b0, r_b} : (r_lo[0] ? {1'b0, r_b} : 33'd0);
    assign w_add_cin = r_op[2];
    assign w_add     = {1'b0, w_add_a} + {1'b0, w_add_b} + {33'd0, w_add_cin};

    assign w_fix_data = r_op[2] ? {neg_if(r_neg_r, r_hi), neg_if(r_neg_q, r_lo)}
                                : (r_neg_q ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    if (w_hit)          w_state_next = ST_DONE;
                    else if (w_special) w_state_next = ST_FIX;
                    else                w_state_next = ST_RUN;
                end
            end
            ST_RUN:  if (r_cnt == 5'd0) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_DONE;
            ST_DONE: if (advance) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (clear) w_state_next = ST_IDLE;
    end

    always_comb begin
        busy = (r_state != ST_IDLE);
        done = (r_state == ST_DONE);
    end

    assign stall_ex = req && !done;
    assign result   = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_b      <= 32'd0;
            r_lhs    <= 32'd0;
            r_rhs    <= 32'd0;
            r_op     <= 3'd0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= 5'd0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op  <= op;
            r_lhs <= lhs;
            r_rhs <= rhs;
            r_cnt <= 5'd31;
            if (w_special) begin
                r_lo    <= w_div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                r_hi    <= w_div_zero ? lhs : 32'd0;
                r_b     <= 32'd0;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_hi    <= 32'd0;
                r_lo    <= op[2] ? w_lhs_mag : w_rhs_mag;
                r_b     <= op[2] ? w_rhs_mag : w_lhs_mag;
                r_neg_q <= w_lhs_neg ^ w_rhs_neg;
                r_neg_r <= w_lhs_neg;
            end
            if (w_hit) r_result <= sel_result(op, w_hit_data);
        end else if (r_state == ST_RUN) begin
            r_cnt <= r_cnt - 5'd1;
            if (r_op[2]) begin
                r_hi <= w_add[33] ? w_add[31:0] : w_add_a[31:0];
                r_lo <= {r_lo[30:0], w_add[33]};
            end else begin
                r_hi <= w_add[32:1];
                r_lo <= {w_add[0], r_lo[31:1]};
            end
        end else if ((r_state == ST_FIX) && !clear) begin
            r_result <= sel_result(r_op, w_fix_data);
        end
    end

endmodule

// File: tb/tb_boa_muldiv_seq.sv
// tb/tb_boa_muldiv_seq.sv - vector table, hand sequences and random ops against a reference model
module tb_boa_muldiv_seq;
    import boa_muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst, clear, req, advance;
    logic [2:0]  op;
    logic [31:0] lhs, rhs;
    logic        busy, stall_ex, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    logic        m_valid = 1'b0;
    logic [31:0] m_lhs, m_rhs;
    logic        m_cls;
    logic [1:0]  m_tag;

    boa_muldiv_seq dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .req      (req),
        .op       (op),
        .lhs      (lhs),
        .rhs      (rhs),
        .advance  (advance),
        .busy     (busy),
        .stall_ex (stall_ex),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        int          qa, qb;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        qa = $signed(a);
        qb = $signed(b);
        case (o)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * $signed({32'd0, b}); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return qa / qb;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return qa % qb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic tag_ok;
        tag_ok = m_cls ? (m_tag[0] == o[0]) : (o[1:0] == 2'b00 || m_tag == o[1:0]);
        if (m_valid && m_lhs == a && m_rhs == b && m_cls == o[2] && tag_ok) return 1;
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
        return 34;
    endfunction

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input int el, input int hold);
        exp_t e;
        int   cyc, stall_cnt;
        bit   got;
        @(negedge clk);
        advance = 1'b0;
        req = 1'b1;
        op  = o;
        lhs = a;
        rhs = b;
        sb.push_back('{er, el});
        #1;
        stall_cnt = stall_ex ? 1 : 0;
        cyc = 0;
        got = 0;
        while (!got && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) got = 1;
            else if (stall_ex) stall_cnt++;
        end
        e = sb.pop_front();
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout actual=no_done required=done_in_%0d", nm, e.lat);
            @(negedge clk);
            req = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            m_valid = 1'b0;
            return;
        end
        chk({nm, "_result"}, result, e.res);
        chk({nm, "_latency"}, cyc, e.lat);
        chk({nm, "_stall_cycles"}, stall_cnt, e.lat);
        chk({nm, "_stall_at_done"}, {31'd0, stall_ex}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s_hold%0d_done", nm, h), {31'd0, done}, 32'd1);
            chk($sformatf("%s_hold%0d_result", nm, h), result, e.res);
        end
        if (el != 1) begin
            m_valid = 1'b1;
            m_lhs = a;
            m_rhs = b;
            m_cls = o[2];
            m_tag = o[2] ? {1'b0, o[0]} : o[1:0];
        end
        @(negedge clk);
        advance = 1'b1;
        req = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_idle_after_adv"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        rst = 1'b1; clear = 1'b0; req = 1'b1; advance = 1'b0;
        op = RV_MUL_MUL; lhs = 32'd3; rhs = 32'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        #1;
        chk("rst_stall", {31'd0, stall_ex}, 32'd0);

        vecs.push_back('{RV_MUL_MUL,    32'd7,          32'd6,          32'd42,         34});
        vecs.push_back('{RV_MUL_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,  34});
        vecs.push_back('{RV_MUL_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  1});
        vecs.push_back('{RV_MUL_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  34});
        vecs.push_back('{RV_MUL_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  34});
        vecs.push_back('{RV_MUL_DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34});
        vecs.push_back('{RV_MUL_REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1});
        vecs.push_back('{RV_MUL_DIVU,   32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  34});
        vecs.push_back('{RV_MUL_REMU,   32'hFFFF_FFF9,  32'd2,          32'd1,          1});
        vecs.push_back('{RV_MUL_DIV,    32'd5,          32'd0,          32'hFFFF_FFFF,  2});
        vecs.push_back('{RV_MUL_REM,    32'd5,          32'd0,          32'd5,          1});
        vecs.push_back('{RV_MUL_REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2});
        vecs.push_back('{RV_MUL_DIVU,   32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34});
        vecs.push_back('{RV_MUL_MUL,    32'h8000_0000,  32'h8000_0000,  32'd0,          34});
        vecs.push_back('{RV_MUL_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  34});
        vecs.push_back('{RV_MUL_DIV,    32'd100,        32'hFFFF_FFFD,  32'hFFFF_FFDF,  34});
        vecs.push_back('{RV_MUL_REM,    32'd100,        32'hFFFF_FFFD,  32'd1,          1});
        vecs.push_back('{RV_MUL_REM,    32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  34});
        vecs.push_back('{RV_MUL_MUL,    32'd7,          32'd6,          32'd42,         34});

        foreach (vecs[i])
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 0);

        do_op("hold", RV_MUL_DIVU, 32'd1000, 32'd7, 32'd142, 34, 5);

        @(negedge clk);
        advance = 1'b0; req = 1'b1; op = RV_MUL_MUL; lhs = 32'd1000; rhs = 32'd3000;
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        chk("clr_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        clear = 1'b1; req = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_busy_after", {31'd0, busy}, 32'd0);
        chk("clr_done_after", {31'd0, done}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        m_valid = 1'b0;
        do_op("clr_prev_miss", RV_MUL_DIVU, 32'd1000, 32'd7, 32'd142, 34, 0);
        do_op("clr_repeat", RV_MUL_MUL, 32'd1000, 32'd3000, 32'd3000000, 34, 0);

        ra = 32'd0;
        rb = 32'd0;
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(0, 7));
            if (i == 0 || $urandom_range(0, 1) == 0) begin
                ra = $urandom;
                rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
            end
            do_op($sformatf("rnd%0d", i), ro, ra, rb, model_res(ro, ra, rb), model_lat(ro, ra, rb), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
